ms_port_ctrl: RTL and testbench

// - Parametrised mixed-signal port controller. Sits between the digital control core and the

---
 rtl/ms_port_ctrl.sv | 147 ++++++++++++++
 tb/tb_ms_port_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ms_port_ctrl.sv
// ============================================================================
// Module   : ms_port_ctrl
// Purpose  : Mixed-signal port controller with synchronised, optionally
//            debounced inputs, sticky edge events with a masked interrupt, and
//            double-buffered output words behind a req/ack register port.
//            Macro MS_PORT_DEBOUNCE_EN enables the per-channel debounce counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_port_ctrl #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 2,
    parameter int W       = 8,
    parameter int DEB_CNT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_IN-1:0]      ms_i,
    output logic [N_OUT*W-1:0]   ms_o,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [3:0]           reg_addr_i,
    input  logic [7:0]           reg_wdata_i,
    output logic [7:0]           reg_rdata_o,
    output logic                 reg_ack_o,
    output logic                 irq_o
);

    if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 4 || W < 1 || W > 8 ||
        DEB_CNT < 1 || DEB_CNT > 15) begin : g_bad_param
        $error("ms_port_ctrl: parameter out of range");
    end

    localparam logic [3:0] C_ADDR_LEVEL  = 4'h0;
    localparam logic [3:0] C_ADDR_EVENT  = 4'h1;
    localparam logic [3:0] C_ADDR_MASK   = 4'h2;

    logic [N_IN-1:0] r_sync1, r_sync2, r_filt, w_filt_nxt;
    logic [N_IN-1:0] r_event, r_mask, w_ev_clr;
    logic [W-1:0]    r_shadow [N_OUT];
    logic [W-1:0]    r_active [N_OUT];
    logic            r_busy, w_access, w_wr;
    logic [7:0]      w_rd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
        end else begin
            r_sync1 <= ms_i;
            r_sync2 <= r_sync1;
            r_filt  <= w_filt_nxt;
        end
    end

`ifdef MS_PORT_DEBOUNCE_EN
    localparam logic [3:0] C_DEB_LAST = 4'(DEB_CNT - 1);

    logic [3:0] r_cnt     [N_IN];
    logic [3:0] w_cnt_nxt [N_IN];

    // The level flips on the cycle the count would reach DEB_CNT, so the
    // counter only ever holds 0..DEB_CNT-1.
    always_comb begin
        w_filt_nxt = r_filt;
        for (int i = 0; i < N_IN; i++) begin
            w_cnt_nxt[i] = 4'd0;
            if (r_sync2[i] != r_filt[i]) begin
                if (r_cnt[i] == C_DEB_LAST) begin
                    w_filt_nxt[i] = ~r_filt[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_IN; i++) r_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < N_IN; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end
`else
    assign w_filt_nxt = r_sync2;
`endif

    // r_busy holds off re-execution until the master drops its request.
    assign w_access = reg_req_i & ~r_busy;
    assign w_wr     = w_access & reg_we_i;
    assign w_ev_clr = (w_wr && reg_addr_i == C_ADDR_EVENT) ? reg_wdata_i[N_IN-1:0] : '0;

    always_comb begin
        w_rd = 8'h00;
        case (reg_addr_i)
            C_ADDR_LEVEL: w_rd[N_IN-1:0] = r_filt;
            C_ADDR_EVENT: w_rd[N_IN-1:0] = r_event;
            C_ADDR_MASK:  w_rd[N_IN-1:0] = r_mask;
            default: begin
                for (int n = 0; n < N_OUT; n++) begin
                    if (reg_addr_i == 4'(4 + n)) w_rd[W-1:0] = r_shadow[n];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy      <= 1'b0;
            reg_ack_o   <= 1'b0;
            reg_rdata_o <= 8'h00;
            r_event     <= '0;
            r_mask      <= '0;
            irq_o       <= 1'b0;
            for (int n = 0; n < N_OUT; n++) begin
                r_shadow[n] <= '0;
                r_active[n] <= '0;
            end
        end else begin
            r_busy      <= w_access | (r_busy & reg_req_i);
            reg_ack_o   <= w_access;
            reg_rdata_o <= (w_access && !reg_we_i) ? w_rd : 8'h00;
            // A new edge on the clear cycle survives the W1C.
            r_event     <= (r_event & ~w_ev_clr) | (w_filt_nxt ^ r_filt);
            irq_o       <= |(r_event & r_mask);
            if (w_wr) begin
                if (reg_addr_i == C_ADDR_MASK) r_mask <= reg_wdata_i[N_IN-1:0];
                if (reg_addr_i == 4'h3) begin
                    for (int n = 0; n < N_OUT; n++) r_active[n] <= r_shadow[n];
                end
                for (int n = 0; n < N_OUT; n++) begin
                    if (reg_addr_i == 4'(4 + n)) r_shadow[n] <= reg_wdata_i[W-1:0];
                end
            end
        end
    end

    for (genvar n = 0; n < N_OUT; n++) begin : g_out
        assign ms_o[n*W +: W] = r_active[n];
    end

endmodule

`default_nettype wire

// File: tb/tb_ms_port_ctrl.sv
// ============================================================================
// Module   : tb_ms_port_ctrl
// Purpose  : Directed self-checking bench for ms_port_ctrl (table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ms_port_ctrl;

`ifdef MS_PORT_DEBOUNCE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ms_i;
    logic [15:0] ms_o;
    logic        reg_req, reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;
    logic        reg_ack, irq;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rd;
    logic        irq_at_ack;
    logic [15:0] ms_at_ack;
    int          acks;

    ms_port_ctrl #(.N_IN(4), .N_OUT(2), .W(8), .DEB_CNT(3)) dut (
        .clk_i(clk), .rst_i(rst), .ms_i(ms_i), .ms_o(ms_o),
        .reg_req_i(reg_req), .reg_we_i(reg_we), .reg_addr_i(reg_addr),
        .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata), .reg_ack_o(reg_ack),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic [15:0] exp_ms;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_access(input logic we, input logic [3:0] addr, input logic [7:0] wd);
        bit got = 1'b0;
        reg_req = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = wd;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (reg_ack) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout addr=0x%0h actual=0 expected=1", addr);
        end
        rd = reg_rdata; irq_at_ack = irq; ms_at_ack = ms_o;
        reg_req = 1'b0; reg_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [7:0] exp);
        reg_access(1'b0, addr, 8'h00);
        check(name, {24'h0, rd}, {24'h0, exp});
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 16'h0000};
        vecs[1]  = '{1'b1, 4'h4, 8'hA5, 1'b0, 8'h00, 16'h0000};
        vecs[2]  = '{1'b1, 4'h5, 8'h3C, 1'b0, 8'h00, 16'h0000};
        vecs[3]  = '{1'b0, 4'h4, 8'h00, 1'b1, 8'hA5, 16'h0000};
        vecs[4]  = '{1'b0, 4'h5, 8'h00, 1'b1, 8'h3C, 16'h0000};
        vecs[5]  = '{1'b0, 4'hF, 8'h00, 1'b1, 8'h00, 16'h0000};
        vecs[6]  = '{1'b0, 4'h3, 8'h00, 1'b1, 8'h00, 16'h0000};
        vecs[7]  = '{1'b1, 4'h3, 8'h00, 1'b0, 8'h00, 16'h3CA5};
        vecs[8]  = '{1'b1, 4'h2, 8'hFF, 1'b0, 8'h00, 16'h3CA5};
        vecs[9]  = '{1'b0, 4'h2, 8'h00, 1'b1, 8'h0F, 16'h3CA5};
        vecs[10] = '{1'b1, 4'h2, 8'h02, 1'b0, 8'h00, 16'h3CA5};
        vecs[11] = '{1'b0, 4'h2, 8'h00, 1'b1, 8'h02, 16'h3CA5};
        vecs[12] = '{1'b1, 4'hF, 8'h55, 1'b0, 8'h00, 16'h3CA5};
        vecs[13] = '{1'b1, 4'h4, 8'h11, 1'b0, 8'h00, 16'h3CA5};
        vecs[14] = '{1'b0, 4'h6, 8'h00, 1'b1, 8'h00, 16'h3CA5};

        rst = 1'b1; ms_i = 4'h0;
        reg_req = 1'b0; reg_we = 1'b0; reg_addr = 4'h0; reg_wdata = 8'h00;
        #3;
        check("reset_ms_o",  {16'h0, ms_o}, 32'h0);
        check("reset_irq",   {31'h0, irq}, 32'h0);
        check("reset_ack",   {31'h0, reg_ack}, 32'h0);
        check("reset_rdata", {24'h0, reg_rdata}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 15; v++) begin
            reg_access(vecs[v].we, vecs[v].addr, vecs[v].wdata);
            if (vecs[v].chk_rd)
                check($sformatf("vec%0d_rdata", v), {24'h0, rd}, {24'h0, vecs[v].exp_rd});
            check($sformatf("vec%0d_ms_o", v), {16'h0, ms_at_ack}, {16'h0, vecs[v].exp_ms});
        end
        rd_check("shadow0_after_rewrite", 4'h4, 8'h11);

`ifdef MS_PORT_DEBOUNCE_EN
        ms_i = 4'b0001;
        repeat (2) @(posedge clk);
        #1 ms_i = 4'b0000;
        repeat (8) @(posedge clk);
        #1;
        rd_check("glitch_level", 4'h0, 8'h00);
        rd_check("glitch_event", 4'h1, 8'h00);
`endif

        // ch1 rises before edge k: EVENT at k+1+LAT, irq at k+2+LAT
        ms_i = 4'b0010;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("irq_before_event_latency", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_after_event_latency", {31'h0, irq}, 32'h1);
        rd_check("level_ch1", 4'h0, 8'h02);
        rd_check("event_ch1", 4'h1, 8'h02);

        reg_access(1'b1, 4'h1, 8'h02);
        check("irq_on_clear_edge", {31'h0, irq_at_ack}, 32'h1);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        rd_check("event_cleared", 4'h1, 8'h00);

        // ch1 falls so that filt changes on the same edge as the W1C
        ms_i = 4'b0000;
        repeat (LAT + 1) @(posedge clk);
        #1;
        reg_access(1'b1, 4'h1, 8'h02);
        rd_check("event_set_wins", 4'h1, 8'h02);
        rd_check("level_ch1_low", 4'h0, 8'h00);
        check("irq_after_set_wins", {31'h0, irq}, 32'h1);

        acks = 0;
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = 4'h2; reg_wdata = 8'h0A;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (reg_ack) acks++;
        end
        reg_req = 1'b0; reg_we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (reg_ack) acks++;
        end
        check("held_req_ack_count", acks, 32'd1);
        rd_check("mask_after_held", 4'h2, 8'h0A);

        check("ms_o_before_reset", {16'h0, ms_o}, 32'h3CA5);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = 4'h2;
        @(posedge clk); #2;
        check("ack_before_reset", {31'h0, reg_ack}, 32'h1);
        rst = 1'b1;
        #1;
        check("midcycle_rst_ack",  {31'h0, reg_ack}, 32'h0);
        check("midcycle_rst_ms_o", {16'h0, ms_o}, 32'h0);
        check("midcycle_rst_irq",  {31'h0, irq}, 32'h0);
        reg_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rd_check("level_after_reset", 4'h0, 8'h00);
        rd_check("mask_after_reset", 4'h2, 8'h00);
        rd_check("shadow1_after_reset", 4'h5, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
